m2s_tracked_bridge: RTL and testbench
=====================================

# m2s_tracked_bridge

Parametrised request/response bridge between the HDL access generator and the multi2sim VPI step logic, replacing the fixed-width two-FIFO pair. It buffers access requests and their served responses in independent first-word-fall-through FIFOs of configurable depth. It allocates transaction IDs from a free list and tracks outstanding transactions, so `next_id_available` is generated in hardware instead of being supplied by the requester.

## Interface
Parameters:
- `ADDR_W`, 31, request address width
- `DATA_W`, 32, request/response data width
- `ID_W`, 4, transaction ID width; `NUM_IDS` = 2**`ID_W`
- `REQ_DEPTH_LOG2`, 3, request FIFO depth = 2**`REQ_DEPTH_LOG2`
- `RSP_DEPTH_LOG2`, 3, response FIFO depth = 2**`RSP_DEPTH_LOG2`

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  1  requester offers access
- `req_ready`  out  1  = request FIFO not full AND `id_avail`
- `req_rw`  in  1  1 = write, 0 = read
- `req_addr`  in  `ADDR_W`  access address
- `req_data`  in  `DATA_W`  write data
- `req_id`  out  `ID_W`  ID assigned to the current offer; equals `next_id_out`
- `sim_req_valid`  out  1  request FIFO not empty
- `sim_req_ready`  in  1  simulator side pops head
- `sim_req_rw`, `sim_req_addr`, `sim_req_data`, `sim_req_id`  out  1/`ADDR_W`/`DATA_W`/`ID_W`  head entry
- `sim_rsp_valid`  in  1  simulator returns a served access
- `sim_rsp_ready`  out  1  response FIFO not full
- `sim_rsp_id`  in  `ID_W`  ID of the served access
- `sim_rsp_data`  in  `DATA_W`  read data
- `rsp_valid`  out  1  response FIFO not empty
- `rsp_ready`  in  1  requester pops response
- `rsp_id`, `rsp_data`  out  `ID_W`/`DATA_W`  head response
- `next_id_out`  out  `ID_W`  lowest-numbered free ID
- `id_avail`  out  1  at least one free ID
- `outstanding`  out  `ID_W`+1  count of busy IDs
- `err_bad_id`  out  1  sticky error flag; response carried a non-busy ID

## Operation
- Request accept: `req_valid && req_ready`. Push {rw, addr, data, `next_id_out`}. Mark that ID busy.
- Allocation: priority encoder over the free bitmap picks the lowest free index. It uses the registered bitmap only.
- Request pop: `sim_req_valid && sim_req_ready`.
- Response accept: `sim_rsp_valid && sim_rsp_ready`. Push {id, data}. No ID state change on push.
- ID release: `rsp_valid && rsp_ready` frees `rsp_id`.
- Freed ID becomes allocatable in the following cycle.
- Allocate and free in the same cycle, including the same index: both update applied. Allocation bit set wins only if indices differ. Same index is impossible, because a busy ID cannot be allocated.
- `outstanding` counts busy IDs. It ranges 0..`NUM_IDS` and is updated +1, -1, or unchanged on simultaneous alloc/free.
- FIFO pointers: `DEPTH_LOG2`+1 bits. Full when the MSBs differ and the LSBs are equal. Wrap-around is natural.
- Pop while empty: ignored.
- Push while full: cannot occur, because ready is low.
- Simultaneous push and pop on a non-empty, non-full FIFO: count unchanged.

## Timing
- Reset values (async, asserted on `rst_n`=0):
  - FIFOs empty; bitmap all free
  - `req_ready`=1, `sim_req_valid`=0, `sim_rsp_ready`=1, `rsp_valid`=0
  - `next_id_out`=0, `req_id`=0, `id_avail`=1, `outstanding`=0, `err_bad_id`=0
  - All data outputs 0
- Request latency: accepted at edge N → `sim_req_valid`=1 after edge N. No combinational bypass.
- Response latency: same, one edge.
- Ready when full: `req_ready` and `sim_rsp_ready` depend on registered full only. A pop in the same cycle does not raise ready until the next cycle.
- ID exhaustion: when all IDs are busy, `id_avail`=0 and `req_ready`=0 regardless of FIFO space.
- Mid-operation reset: all in-flight entries and busy IDs are discarded immediately. Outputs return to reset values asynchronously.

## Configuration
- `M2S_BRIDGE_ID_CHECK_EN` defined:
  - A response whose `sim_rsp_id` is not busy is accepted (handshake completes) but dropped.
  - `err_bad_id` is set and held until reset.
- Not defined:
  - Every accepted response is pushed.
  - `err_bad_id` is tied to 0.
  - Popping a response with a free ID leaves the bitmap unchanged.

## Test plan
- Reset release, one write (addr 0x10, data 0xA5) → `req_id`=0. `sim_req_valid` is high one cycle later with `sim_req_addr`=0x10 and `sim_req_id`=0. `outstanding`=1, `next_id_out`=1.
- 16 requests with `sim_req_ready`=0 and defaults → `req_ready` drops after 8 accepted (FIFO full). `outstanding`=8. After draining, accepts continue until 16 IDs are busy; then `id_avail`=0.
- Response id 3, data 0xDEAD, `rsp_ready`=1 → `rsp_valid` next cycle with `rsp_id`=3. ID 3 is free the cycle after the pop, and `next_id_out`=3 if it is the lowest free ID.
- Simultaneous request accept and response pop freeing id 0 → `outstanding` unchanged. New request takes the current lowest free ID, not 0. ID 0 is available next cycle.
- `M2S_BRIDGE_ID_CHECK_EN` build: response with free id 7 → no `rsp_valid`, `err_bad_id`=1 and stays 1. Same stimulus without the macro → `rsp_valid`=1 with `rsp_id`=7 and `err_bad_id`=0.
- Assert `rst_n`=0 with 5 outstanding and 2 queued responses → all outputs take reset values immediately. The first request after release receives ID 0.

Source files
------------

// File: rtl/m2s_tracked_bridge.sv
// Request/response bridge between the HDL access generator and the multi2sim step logic.
// Optional feature macro: M2S_BRIDGE_ID_CHECK_EN (drop responses for non-busy IDs, sticky err_bad_id).

module m2s_tracked_bridge_fifo #(
  parameter int W          = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PTR_W = DEPTH_LOG2 + 1;

  logic [W-1:0]     mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic             empty_s;
  logic             full_s;
  logic             pop_ok_s;

  assign empty_s  = (wr_ptr_r == rd_ptr_r);
  assign full_s   = (wr_ptr_r[DEPTH_LOG2] != rd_ptr_r[DEPTH_LOG2]) &&
                    (wr_ptr_r[DEPTH_LOG2-1:0] == rd_ptr_r[DEPTH_LOG2-1:0]);
  assign pop_ok_s = pop && !empty_s;
  assign empty    = empty_s;
  assign full     = full_s;
  // Head is forced to zero while empty so stale storage never reaches the ports.
  assign rdata    = empty_s ? {W{1'b0}} : mem_r[rd_ptr_r[DEPTH_LOG2-1:0]];

  // Storage write; no reset needed because the head is masked while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr_r[DEPTH_LOG2-1:0]] <= wdata;
    end
  end

  // Read/write pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
    end
  end
endmodule

module m2s_tracked_bridge #(
  parameter int ADDR_W         = 31,
  parameter int DATA_W         = 32,
  parameter int ID_W           = 4,
  parameter int REQ_DEPTH_LOG2 = 3,
  parameter int RSP_DEPTH_LOG2 = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic [ID_W-1:0]   req_id,
  output logic              sim_req_valid,
  input  logic              sim_req_ready,
  output logic              sim_req_rw,
  output logic [ADDR_W-1:0] sim_req_addr,
  output logic [DATA_W-1:0] sim_req_data,
  output logic [ID_W-1:0]   sim_req_id,
  input  logic              sim_rsp_valid,
  output logic              sim_rsp_ready,
  input  logic [ID_W-1:0]   sim_rsp_id,
  input  logic [DATA_W-1:0] sim_rsp_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ID_W-1:0]   rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ID_W-1:0]   next_id_out,
  output logic              id_avail,
  output logic [ID_W:0]     outstanding,
  output logic              err_bad_id
);
  localparam int NUM_IDS = 1 << ID_W;
  localparam int OUT_W   = ID_W + 1;
  localparam int REQ_W   = 1 + ADDR_W + DATA_W + ID_W;
  localparam int RSP_W   = ID_W + DATA_W;

  logic [NUM_IDS-1:0] busy_r;
  logic [OUT_W-1:0]   outstanding_r;
  logic [ID_W-1:0]    next_id_s;
  logic               id_avail_s;
  logic               req_full_s;
  logic               req_empty_s;
  logic               rsp_full_s;
  logic               rsp_empty_s;
  logic               req_fire_s;
  logic               rsp_in_fire_s;
  logic               rsp_push_s;
  logic               rsp_pop_s;
  logic               free_s;
  logic [NUM_IDS-1:0] alloc_mask_s;
  logic [NUM_IDS-1:0] free_mask_s;
  logic [REQ_W-1:0]   req_head_s;
  logic [RSP_W-1:0]   rsp_head_s;

  // Lowest free ID from the registered bitmap only.
  always_comb begin
    next_id_s = {ID_W{1'b0}};
    for (int i = NUM_IDS - 1; i >= 0; i--) begin
      if (!busy_r[i]) begin
        next_id_s = ID_W'(i);
      end else begin
        next_id_s = next_id_s;
      end
    end
  end

  assign id_avail_s    = ~(&busy_r);
  assign req_fire_s    = req_valid && !req_full_s && id_avail_s;
  assign rsp_in_fire_s = sim_rsp_valid && !rsp_full_s;
  assign rsp_pop_s     = !rsp_empty_s && rsp_ready;
  assign rsp_id        = rsp_head_s[RSP_W-1:DATA_W];
  assign rsp_data      = rsp_head_s[DATA_W-1:0];
  // Releasing an ID that is already free must not disturb the count.
  assign free_s        = rsp_pop_s && busy_r[rsp_id];
  assign alloc_mask_s  = req_fire_s ? (NUM_IDS'(1) << next_id_s) : {NUM_IDS{1'b0}};
  assign free_mask_s   = free_s ? (NUM_IDS'(1) << rsp_id) : {NUM_IDS{1'b0}};

`ifdef M2S_BRIDGE_ID_CHECK_EN
  logic bad_id_s;
  logic err_bad_id_r;

  assign bad_id_s   = rsp_in_fire_s && !busy_r[sim_rsp_id];
  assign rsp_push_s = rsp_in_fire_s && busy_r[sim_rsp_id];
  assign err_bad_id = err_bad_id_r;

  // Sticky flag for responses carrying an ID nobody is waiting on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_bad_id_r <= 1'b0;
    end else if (bad_id_s) begin
      err_bad_id_r <= 1'b1;
    end
  end
`else
  assign rsp_push_s = rsp_in_fire_s;
  assign err_bad_id = 1'b0;
`endif

  // Busy bitmap and outstanding counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r        <= {NUM_IDS{1'b0}};
      outstanding_r <= {OUT_W{1'b0}};
    end else begin
      busy_r <= (busy_r & ~free_mask_s) | alloc_mask_s;
      case ({req_fire_s, free_s})
        2'b10:   outstanding_r <= outstanding_r + OUT_W'(1);
        2'b01:   outstanding_r <= outstanding_r - OUT_W'(1);
        default: outstanding_r <= outstanding_r;
      endcase
    end
  end

  m2s_tracked_bridge_fifo #(.W(REQ_W), .DEPTH_LOG2(REQ_DEPTH_LOG2)) u_req_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req_fire_s),
    .wdata ({req_rw, req_addr, req_data, next_id_s}),
    .pop   (sim_req_ready),
    .rdata (req_head_s),
    .empty (req_empty_s),
    .full  (req_full_s)
  );

  m2s_tracked_bridge_fifo #(.W(RSP_W), .DEPTH_LOG2(RSP_DEPTH_LOG2)) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rsp_push_s),
    .wdata ({sim_rsp_id, sim_rsp_data}),
    .pop   (rsp_ready),
    .rdata (rsp_head_s),
    .empty (rsp_empty_s),
    .full  (rsp_full_s)
  );

  assign {sim_req_rw, sim_req_addr, sim_req_data, sim_req_id} = req_head_s;
  assign sim_req_valid = !req_empty_s;
  assign sim_rsp_ready = !rsp_full_s;
  assign rsp_valid     = !rsp_empty_s;
  assign req_ready     = !req_full_s && id_avail_s;
  assign req_id        = next_id_s;
  assign next_id_out   = next_id_s;
  assign id_avail      = id_avail_s;
  assign outstanding   = outstanding_r;
endmodule

// File: tb/tb_m2s_tracked_bridge.sv
// Scoreboard bench for m2s_tracked_bridge: directed requests/responses, queue-based head checking.

module tb_m2s_tracked_bridge;
  localparam int ADDR_W = 31;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;
`ifdef M2S_BRIDGE_ID_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_rw;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic [ID_W-1:0]   req_id;
  logic              sim_req_valid;
  logic              sim_req_ready;
  logic              sim_req_rw;
  logic [ADDR_W-1:0] sim_req_addr;
  logic [DATA_W-1:0] sim_req_data;
  logic [ID_W-1:0]   sim_req_id;
  logic              sim_rsp_valid;
  logic              sim_rsp_ready;
  logic [ID_W-1:0]   sim_rsp_id;
  logic [DATA_W-1:0] sim_rsp_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [ID_W-1:0]   rsp_id;
  logic [DATA_W-1:0] rsp_data;
  logic [ID_W-1:0]   next_id_out;
  logic              id_avail;
  logic [ID_W:0]     outstanding;
  logic              err_bad_id;

  int checks   = 0;
  int failures = 0;
  logic [67:0] exp_req_q [$];
  logic [35:0] exp_rsp_q [$];

  m2s_tracked_bridge dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_rw        (req_rw),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .req_id        (req_id),
    .sim_req_valid (sim_req_valid),
    .sim_req_ready (sim_req_ready),
    .sim_req_rw    (sim_req_rw),
    .sim_req_addr  (sim_req_addr),
    .sim_req_data  (sim_req_data),
    .sim_req_id    (sim_req_id),
    .sim_rsp_valid (sim_rsp_valid),
    .sim_rsp_ready (sim_rsp_ready),
    .sim_rsp_id    (sim_rsp_id),
    .sim_rsp_data  (sim_rsp_data),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_data      (rsp_data),
    .next_id_out   (next_id_out),
    .id_avail      (id_avail),
    .outstanding   (outstanding),
    .err_bad_id    (err_bad_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Request-side monitor: every popped head must match the oldest issued request.
  always @(negedge clk) begin
    if (rst_n && sim_req_valid && sim_req_ready) begin
      if (exp_req_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sim_req_unexpected: got id %0h expected no entry", sim_req_id);
      end else begin
        chk("sim_req_head", {sim_req_rw, sim_req_addr, sim_req_data, sim_req_id}, exp_req_q.pop_front());
      end
    end
  end

  // Response-side monitor.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_rsp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected: got id %0h expected no entry", rsp_id);
      end else begin
        chk("rsp_head", {rsp_id, rsp_data}, exp_rsp_q.pop_front());
      end
    end
  end

  task automatic send_req(input logic rw, input logic [30:0] addr, input logic [31:0] data,
                          input logic [3:0] exp_id);
    req_rw    = rw;
    req_addr  = addr;
    req_data  = data;
    req_valid = 1'b1;
    for (int n = 0; n < 50 && !req_ready; n++) begin
      @(posedge clk); #1;
    end
    if (!req_ready) begin
      chk("req_ready_wait", req_ready, 1'b1);
      req_valid = 1'b0;
      return;
    end
    chk("req_id", req_id, exp_id);
    exp_req_q.push_back({rw, addr, data, exp_id});
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic send_rsp(input logic [3:0] id, input logic [31:0] data, input bit expect_push);
    sim_rsp_id    = id;
    sim_rsp_data  = data;
    sim_rsp_valid = 1'b1;
    for (int n = 0; n < 50 && !sim_rsp_ready; n++) begin
      @(posedge clk); #1;
    end
    if (!sim_rsp_ready) begin
      chk("sim_rsp_ready_wait", sim_rsp_ready, 1'b1);
      sim_rsp_valid = 1'b0;
      return;
    end
    if (expect_push) exp_rsp_q.push_back({id, data});
    @(posedge clk); #1;
    sim_rsp_valid = 1'b0;
  endtask

  task automatic wait_req_drain();
    for (int n = 0; n < 50 && sim_req_valid; n++) begin
      @(posedge clk); #1;
    end
    chk("sim_req_drain", sim_req_valid, 1'b0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ctrl"}, {req_ready, sim_req_valid, sim_rsp_ready, rsp_valid, id_avail, err_bad_id}, 6'b101010);
    chk({tag, "_ids"}, {next_id_out, req_id, outstanding}, 13'h0);
    chk({tag, "_data"}, {sim_req_rw, sim_req_addr, sim_req_data, sim_req_id, rsp_id, rsp_data}, 104'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_rw = 1'b0; req_addr = '0; req_data = '0;
    sim_req_ready = 1'b0; sim_rsp_valid = 1'b0; sim_rsp_id = '0; sim_rsp_data = '0;
    rsp_ready = 1'b0;
    #12;
    check_reset_vals("reset");
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // First write: one-edge latency, no bypass.
    chk("no_bypass", sim_req_valid, 1'b0);
    send_req(1'b1, 31'h10, 32'hA5, 4'd0);
    chk("first_valid", sim_req_valid, 1'b1);
    chk("first_head", {sim_req_addr, sim_req_id}, {31'h10, 4'd0});
    chk("first_cnt", {outstanding, next_id_out}, {5'd1, 4'd1});

    // Fill the request FIFO with the simulator stalled.
    for (int i = 1; i < 8; i++) send_req(1'b0, 31'h100 + 31'(i), 32'h1000 + 32'(i), 4'(i));
    chk("fifo_full", {req_ready, id_avail, outstanding, next_id_out}, {1'b0, 1'b1, 5'd8, 4'd8});
    sim_req_ready = 1'b1;
    wait_req_drain();
    for (int i = 8; i < 16; i++) send_req(1'b1, 31'h300 + 31'(i), 32'h3000 + 32'(i), 4'(i));
    chk("ids_exhausted", {req_ready, id_avail, outstanding}, {1'b0, 1'b0, 5'd16});
    wait_req_drain();
    chk("exhausted_hold", req_ready, 1'b0);

    // Response for id 3 frees it one cycle after the pop.
    rsp_ready = 1'b1;
    send_rsp(4'd3, 32'hDEAD, 1'b1);
    chk("rsp3_valid", {rsp_valid, rsp_id, outstanding}, {1'b1, 4'd3, 5'd16});
    @(posedge clk); #1;
    chk("rsp3_freed", {outstanding, next_id_out, id_avail}, {5'd15, 4'd3, 1'b1});

    // Same-cycle allocate (id 3) and release (id 0).
    rsp_ready = 1'b0;
    send_rsp(4'd0, 32'hBEEF, 1'b1);
    chk("rsp0_queued", {rsp_valid, outstanding, next_id_out}, {1'b1, 5'd15, 4'd3});
    rsp_ready = 1'b1;
    send_req(1'b0, 31'h20, 32'h55, 4'd3);
    chk("alloc_free_same", {outstanding, next_id_out, id_avail}, {5'd15, 4'd0, 1'b1});

    // Response carrying a non-busy ID.
    send_rsp(4'd7, 32'h77, 1'b1);
    @(posedge clk); #1;
    chk("rsp7_freed", outstanding, 5'd14);
    send_rsp(4'd7, 32'h1234, !CHECK_EN);
    repeat (3) @(posedge clk);
    #1;
    chk("bad_id_flag", {err_bad_id, rsp_valid, outstanding, next_id_out}, {CHECK_EN, 1'b0, 5'd14, 4'd0});
    repeat (3) @(posedge clk);
    #1;
    chk("bad_id_sticky", err_bad_id, CHECK_EN);

    // Clean reset, then build in-flight state and reset mid-operation.
    rst_n = 1'b0;
    exp_req_q.delete();
    exp_rsp_q.delete();
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_req(1'b1, 31'h200 + 31'(i), 32'h2000 + 32'(i), 4'(i));
    send_rsp(4'd1, 32'h11, 1'b1);
    send_rsp(4'd2, 32'h22, 1'b1);
    chk("pre_reset", {outstanding, rsp_valid, err_bad_id}, {5'd5, 1'b1, 1'b0});
    wait_req_drain();
    #2 rst_n = 1'b0;
    exp_req_q.delete();
    exp_rsp_q.delete();
    #1;
    check_reset_vals("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_req(1'b0, 31'h40, 32'h99, 4'd0);
    chk("post_reset_cnt", outstanding, 5'd1);
    wait_req_drain();

    repeat (2) @(posedge clk);
    #1;
    chk("req_q_empty", exp_req_q.size(), 0);
    chk("rsp_q_empty", exp_rsp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
